// File: rtl/button_conditioner_if.sv
// Button bundle between the raw pads and the debounced press pulses.
// buttons_out is a valid-only stream: each high bit is a one-cycle press event with no ready/back-pressure.
interface button_conditioner_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] buttons_in;
    logic [WIDTH-1:0] buttons_out;

    modport master (
        output buttons_in,
        input  buttons_out
    );

    modport slave (
        input  buttons_in,
        output buttons_out
    );
endinterface

// File: rtl/button_conditioner.sv
// Per-button 2-flop synchronizer, tick-sampled saturating debouncer and rising-edge
// detector producing one registered pulse per accepted press.
module button_conditioner #(
    parameter int WIDTH          = 4,
    parameter int SAMPLE_CNT_MAX = 62_500,
    parameter int PULSE_CNT_MAX  = 200
) (
    input logic                 clk,
    input logic                 rst_n,
    button_conditioner_if.slave bus
);

    localparam int SC_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
    localparam int DC_W = $clog2(PULSE_CNT_MAX + 1);
    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SAMPLE_CNT_MAX - 1);
    localparam logic [DC_W-1:0] DC_MAX  = DC_W'(PULSE_CNT_MAX);
    localparam logic [DC_W-1:0] DC_ONE  = DC_W'(1);

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [SC_W-1:0]  r_sample_cnt;
    logic [DC_W-1:0]  r_deb_cnt [WIDTH];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_out;

    logic             w_tick;
    logic [WIDTH-1:0] w_deb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.buttons_in;
            r_sync2 <= r_sync1;
        end
    end

    // With SAMPLE_CNT_MAX == 1 the counter sits at 0 == SC_LAST, so tick is permanently high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sample_cnt <= '0;
        end else if (r_sample_cnt == SC_LAST) begin
            r_sample_cnt <= '0;
        end else begin
            r_sample_cnt <= r_sample_cnt + SC_W'(1);
        end
    end

    assign w_tick = (r_sample_cnt == SC_LAST);

    // A low sync level clears immediately; a high level only climbs on ticks and saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_deb_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (!r_sync2[i]) begin
                    r_deb_cnt[i] <= '0;
                end else if (w_tick && (r_deb_cnt[i] < DC_MAX)) begin
                    r_deb_cnt[i] <= r_deb_cnt[i] + DC_ONE;
                end
            end
        end
    end

    always_comb begin
        w_deb = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_deb[i] = (r_deb_cnt[i] == DC_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= '0;
            r_out  <= '0;
        end else begin
            r_prev <= w_deb;
            r_out  <= w_deb & ~r_prev;
        end
    end

    assign bus.buttons_out = r_out;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench: drivers push expected pulses with their edge windows; a negedge monitor
// pops and checks every pulse the conditioner emits.
module tb_button_conditioner;

    localparam int WIDTH  = 4;
    localparam int S_MAX  = 4;
    localparam int P_MAX  = 3;
    localparam int WIN_LO = 12;
    localparam int WIN_HI = 15;

    logic clk;
    logic rst_n;
    int   edge_cnt;

    int   n_checks;
    int   n_pass;

    logic [WIDTH-1:0] exp_q[$];
    int               exp_lo_q[$];
    int               exp_hi_q[$];

    button_conditioner_if #(.WIDTH(WIDTH)) bus ();

    button_conditioner #(
        .WIDTH         (WIDTH),
        .SAMPLE_CNT_MAX(S_MAX),
        .PULSE_CNT_MAX (P_MAX)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // checking helpers
    task automatic check_eq(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got edge %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
    endtask

    // drivers
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [WIDTH-1:0] bits);
        @(negedge clk);
        bus.buttons_in = bits;
    endtask

    // Called right after a rise is driven at a negedge: the pulse is visible after edge t+12..t+15.
    task automatic expect_pulse(input logic [WIDTH-1:0] pat);
        exp_q.push_back(pat);
        exp_lo_q.push_back(edge_cnt + WIN_LO);
        exp_hi_q.push_back(edge_cnt + WIN_HI);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!rst_n) begin
            check_eq("out_zero_in_reset", int'(bus.buttons_out), 0);
        end else if (bus.buttons_out != '0) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_pulse", int'(bus.buttons_out), 0);
            end else begin
                logic [WIDTH-1:0] pat;
                int lo;
                int hi;
                pat = exp_q.pop_front();
                lo  = exp_lo_q.pop_front();
                hi  = exp_hi_q.pop_front();
                check_eq("pulse_pattern", int'(bus.buttons_out), int'(pat));
                check_range("pulse_timing", edge_cnt, lo, hi);
            end
        end
    end

    // stimulus
    initial begin
        int missing;
        n_checks       = 0;
        n_pass         = 0;
        rst_n          = 1'b0;
        bus.buttons_in = 4'b1111;

        // 1: all held through reset -> one combined pulse after full debounce
        wait_cycles(5);
        @(negedge clk);
        rst_n = 1'b1;
        expect_pulse(4'b1111);
        wait_cycles(25);
        drive(4'b0000);
        wait_cycles(10);

        // 2: clean press on bit 0, then held for 100 quiet cycles
        drive(4'b0001);
        expect_pulse(4'b0001);
        wait_cycles(20 + 100);
        drive(4'b0000);
        wait_cycles(10);

        // 3: bit 1 bounces (3 high / 3 low) for 60 cycles, then settles high
        for (int k = 0; k < 10; k++) begin
            drive(4'b0010);
            wait_cycles(2);
            drive(4'b0000);
            wait_cycles(2);
        end
        drive(4'b0010);
        expect_pulse(4'b0010);
        wait_cycles(30);
        drive(4'b0000);
        wait_cycles(10);

        // 4: bit 2 press, 2-cycle release, re-press -> two pulses, none on release
        drive(4'b0100);
        expect_pulse(4'b0100);
        wait_cycles(20);
        drive(4'b0000);
        wait_cycles(1);
        drive(4'b0100);
        expect_pulse(4'b0100);
        wait_cycles(20);
        drive(4'b0000);
        wait_cycles(10);

        // 5: bits 0 and 3 rise together
        drive(4'b1001);
        expect_pulse(4'b1001);
        wait_cycles(25);
        drive(4'b0000);
        wait_cycles(10);

        // 6: bit 0 pressed, async reset at edge 8 for 3 cycles, still held
        drive(4'b0001);
        repeat (8) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        expect_pulse(4'b0001);
        wait_cycles(25);
        drive(4'b0000);
        wait_cycles(40);

        // final report
        missing = exp_q.size();
        check_eq("all_expected_pulses_seen", missing, 0);
        while (exp_q.size() > 0) begin
            logic [WIDTH-1:0] pat;
            int lo;
            int hi;
            pat = exp_q.pop_front();
            lo  = exp_lo_q.pop_front();
            hi  = exp_hi_q.pop_front();
            $display("missing pulse %b expected at edges %0d..%0d", pat, lo, hi);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
